// File: rtl/mux_sync_multi_if.sv
// rtl/mux_sync_multi_if.sv - per-channel bus, enable and handshake bundle for mux_sync_multi
interface mux_sync_multi_if #(
    parameter int NUM_CH    = 2,
    parameter int BUS_WIDTH = 8
);
    logic [NUM_CH*BUS_WIDTH-1:0] Unsync_Bus;
    logic [NUM_CH-1:0]           Enable;
    logic [NUM_CH-1:0]           Data_Ack;
    logic [NUM_CH-1:0]           Ovr_Clr;
    logic [NUM_CH*BUS_WIDTH-1:0] Sync_Bus;
    logic [NUM_CH-1:0]           Enable_Pulse;
    logic [NUM_CH-1:0]           Data_Valid;
    logic [NUM_CH-1:0]           Overrun;
    logic [NUM_CH-1:0]           Ack_Toggle;

    modport master (
        output Unsync_Bus, Enable, Data_Ack, Ovr_Clr,
        input  Sync_Bus, Enable_Pulse, Data_Valid, Overrun, Ack_Toggle
    );

    modport slave (
        input  Unsync_Bus, Enable, Data_Ack, Ovr_Clr,
        output Sync_Bus, Enable_Pulse, Data_Valid, Overrun, Ack_Toggle
    );
endinterface

// File: rtl/mux_sync_multi.sv
// rtl/mux_sync_multi.sv - multi-channel bus synchronizer with valid/ack handshake and overrun flag
module mux_sync_multi #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_CH     = 2,
    parameter int EN_MODE    = 0,
    parameter int OVERWRITE  = 1
) (
    input  logic            clk,
    input  logic            rst,
    mux_sync_multi_if.slave chan_if
);
    localparam logic TOGGLE_MODE  = (EN_MODE != 0);
    localparam logic OVERWRITE_EN = (OVERWRITE != 0);

    logic [NUM_STAGES-1:0][NUM_CH-1:0] sync_q;
    logic [NUM_CH-1:0]                 en_cur_q;
    logic [NUM_CH-1:0]                 en_prev_q;
    logic [NUM_CH*BUS_WIDTH-1:0]       sync_bus_q, sync_bus_d;
    logic [NUM_CH-1:0]                 pulse_q, pulse_d;
    logic [NUM_CH-1:0]                 valid_q, valid_d;
    logic [NUM_CH-1:0]                 ovr_q, ovr_d;
    logic [NUM_CH-1:0]                 tog_q, tog_d;
    logic [NUM_CH-1:0]                 en_event;
    logic [NUM_CH-1:0]                 accept;
    logic [NUM_CH-1:0]                 ovr_set;
    logic [NUM_CH-1:0]                 load;
    logic [NUM_CH-1:0]                 ack_ok;

    always_comb begin
        en_event   = TOGGLE_MODE ? (en_cur_q ^ en_prev_q) : (en_cur_q & ~en_prev_q);
        ack_ok     = chan_if.Data_Ack & valid_q;
        // An ack in the capture cycle frees the slot, so the new word is accepted cleanly.
        accept     = en_event & (~valid_q | chan_if.Data_Ack);
        ovr_set    = en_event & valid_q & ~chan_if.Data_Ack;
        load       = accept | (ovr_set & {NUM_CH{OVERWRITE_EN}});
        pulse_d    = load;
        valid_d    = (valid_q & ~ack_ok) | accept;
        tog_d      = tog_q ^ ack_ok;
        ovr_d      = ovr_set | (ovr_q & ~chan_if.Ovr_Clr);
        sync_bus_d = sync_bus_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (load[c]) begin
                sync_bus_d[c*BUS_WIDTH +: BUS_WIDTH] = chan_if.Unsync_Bus[c*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    // en_cur_q/en_prev_q form the edge detector after the synchronizer proper.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q     <= '0;
            en_cur_q   <= '0;
            en_prev_q  <= '0;
            sync_bus_q <= '0;
            pulse_q    <= '0;
            valid_q    <= '0;
            ovr_q      <= '0;
            tog_q      <= '0;
        end else begin
            sync_q     <= {sync_q[NUM_STAGES-2:0], chan_if.Enable};
            en_cur_q   <= sync_q[NUM_STAGES-1];
            en_prev_q  <= en_cur_q;
            sync_bus_q <= sync_bus_d;
            pulse_q    <= pulse_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
            tog_q      <= tog_d;
        end
    end

    assign chan_if.Sync_Bus     = sync_bus_q;
    assign chan_if.Enable_Pulse = pulse_q;
    assign chan_if.Data_Valid   = valid_q;
    assign chan_if.Overrun      = ovr_q;
    assign chan_if.Ack_Toggle   = tog_q;
endmodule

// File: tb/tb_mux_sync_multi.sv
// tb/tb_mux_sync_multi.sv - self-checking bench for mux_sync_multi in three configurations
module tb_mux_sync_multi;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  en;
    logic [15:0] unsync;
    logic [1:0]  ack;
    logic [1:0]  clr;

    always #5 clk = ~clk;

    // a: level/overwrite, b: level/drop, c: toggle/overwrite with a 3-deep synchronizer
    mux_sync_multi_if #(.NUM_CH(2), .BUS_WIDTH(8)) ifa ();
    mux_sync_multi_if #(.NUM_CH(2), .BUS_WIDTH(8)) ifb ();
    mux_sync_multi_if #(.NUM_CH(2), .BUS_WIDTH(8)) ifc ();

    assign ifa.Unsync_Bus = unsync;
    assign ifa.Enable     = en;
    assign ifa.Data_Ack   = ack;
    assign ifa.Ovr_Clr    = clr;
    assign ifb.Unsync_Bus = unsync;
    assign ifb.Enable     = en;
    assign ifb.Data_Ack   = ack;
    assign ifb.Ovr_Clr    = clr;
    assign ifc.Unsync_Bus = unsync;
    assign ifc.Enable     = en;
    assign ifc.Data_Ack   = ack;
    assign ifc.Ovr_Clr    = clr;

    mux_sync_multi #(.NUM_STAGES(2), .BUS_WIDTH(8), .NUM_CH(2), .EN_MODE(0), .OVERWRITE(1))
        dut_a (.clk(clk), .rst(rst), .chan_if(ifa));
    mux_sync_multi #(.NUM_STAGES(2), .BUS_WIDTH(8), .NUM_CH(2), .EN_MODE(0), .OVERWRITE(0))
        dut_b (.clk(clk), .rst(rst), .chan_if(ifb));
    mux_sync_multi #(.NUM_STAGES(3), .BUS_WIDTH(8), .NUM_CH(2), .EN_MODE(1), .OVERWRITE(1))
        dut_c (.clk(clk), .rst(rst), .chan_if(ifc));

    // {pulse[1:0], valid[1:0], overrun[1:0], ack_toggle[1:0], sync_bus[15:0]}
    logic [23:0] obs [3];
    assign obs[0] = {ifa.Enable_Pulse, ifa.Data_Valid, ifa.Overrun, ifa.Ack_Toggle, ifa.Sync_Bus};
    assign obs[1] = {ifb.Enable_Pulse, ifb.Data_Valid, ifb.Overrun, ifb.Ack_Toggle, ifb.Sync_Bus};
    assign obs[2] = {ifc.Enable_Pulse, ifc.Data_Valid, ifc.Overrun, ifc.Ack_Toggle, ifc.Sync_Bus};

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: enable samples are kept as a history; an event is seen NUM_STAGES+1 edges after sampling.
    logic [1:0]  m_hist  [3][8];
    logic [1:0]  m_pulse [3];
    logic [1:0]  m_valid [3];
    logic [1:0]  m_ovr   [3];
    logic [1:0]  m_tog   [3];
    logic [15:0] m_bus   [3];

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            int ns  = (i == 2) ? 3 : 2;
            bit tgl = (i == 2);
            bit ow  = (i != 1);
            if (!rst) begin
                for (int k = 0; k < 8; k++) m_hist[i][k] = 2'b00;
                m_pulse[i] = 2'b00;
                m_valid[i] = 2'b00;
                m_ovr[i]   = 2'b00;
                m_tog[i]   = 2'b00;
                m_bus[i]   = 16'h0000;
            end else begin
                for (int k = 7; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
                m_hist[i][0] = en;
                m_pulse[i] = 2'b00;
                for (int c = 0; c < 2; c++) begin
                    logic now_v     = m_hist[i][ns+1][c];
                    logic old_v     = m_hist[i][ns+2][c];
                    bit   ev        = tgl ? (now_v != old_v) : (now_v && !old_v);
                    bit   was_valid = m_valid[i][c];
                    bit   set_ovr   = 1'b0;
                    if (ev) begin
                        if (!was_valid || ack[c]) begin
                            m_bus[i][c*8 +: 8] = unsync[c*8 +: 8];
                            m_pulse[i][c]      = 1'b1;
                            m_valid[i][c]      = 1'b1;
                        end else begin
                            set_ovr = 1'b1;
                            if (ow) begin
                                m_bus[i][c*8 +: 8] = unsync[c*8 +: 8];
                                m_pulse[i][c]      = 1'b1;
                            end
                        end
                    end
                    if (ack[c] && was_valid) begin
                        m_tog[i][c] = ~m_tog[i][c];
                        if (!ev) m_valid[i][c] = 1'b0;
                    end
                    if (set_ovr) m_ovr[i][c] = 1'b1;
                    else if (clr[c]) m_ovr[i][c] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  en;
        logic [15:0] bus;
        logic [1:0]  ack;
        logic [1:0]  clr;
        logic [23:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [1:0] e, input logic [15:0] b,
                                input logic [1:0] a, input logic [1:0] c,
                                input logic [1:0] p, input logic [1:0] v, input logic [1:0] o,
                                input logic [1:0] t, input logic [15:0] sb);
        vec_t x;
        x.rst = r;
        x.en  = e;
        x.bus = b;
        x.ack = a;
        x.clr = c;
        x.exp = {p, v, o, t, sb};
        return x;
    endfunction

    vec_t tbl [26];

    initial begin
        int pulses;
        rst    = 1'b0;
        en     = 2'b00;
        unsync = 16'h0000;
        ack    = 2'b00;
        clr    = 2'b00;

        tbl[0]  = mk(1'b0, 2'b11, 16'hFFFF, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000);
        tbl[1]  = mk(1'b0, 2'b11, 16'hFFFF, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000);
        for (int i = 2; i < 6; i++)
            tbl[i] = mk(1'b1, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000);
        for (int i = 6; i < 9; i++)
            tbl[i] = mk(1'b1, 2'b01, 16'h00A5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000);
        tbl[9]  = mk(1'b1, 2'b01, 16'h00A5, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 16'h00A5);
        tbl[10] = mk(1'b1, 2'b01, 16'h00A5, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 16'h00A5);
        tbl[11] = mk(1'b1, 2'b01, 16'h00A5, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 16'h00A5);
        tbl[12] = mk(1'b1, 2'b01, 16'h00A5, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 16'h00A5);
        tbl[13] = mk(1'b1, 2'b01, 16'h00A5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 16'h00A5);
        tbl[14] = mk(1'b1, 2'b00, 16'h00A5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 16'h00A5);
        for (int i = 15; i < 18; i++)
            tbl[i] = mk(1'b1, 2'b01, 16'h0011, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 16'h00A5);
        tbl[18] = mk(1'b1, 2'b01, 16'h0011, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 16'h0011);
        tbl[19] = mk(1'b1, 2'b00, 16'h0022, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 16'h0011);
        for (int i = 20; i < 23; i++)
            tbl[i] = mk(1'b1, 2'b01, 16'h0022, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 16'h0011);
        tbl[23] = mk(1'b1, 2'b01, 16'h0022, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 16'h0022);
        tbl[24] = mk(1'b1, 2'b01, 16'h0022, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 16'h0022);
        tbl[25] = mk(1'b1, 2'b01, 16'h0022, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 16'h0022);

        // Reset, latency, handshake and overwrite-overrun sequence on the level/overwrite instance.
        for (int i = 0; i < 26; i++) begin
            rst    = tbl[i].rst;
            en     = tbl[i].en;
            unsync = tbl[i].bus;
            ack    = tbl[i].ack;
            clr    = tbl[i].clr;
            step();
            check($sformatf("vec%0d", i), obs[0], tbl[i].exp);
            if (i == 23)
                check("drop_policy_overrun", obs[1], {2'b00, 2'b01, 2'b01, 2'b01, 16'h0011});
        end
        clr = 2'b00;

        // Ack arriving in the same cycle as a ch1 capture.
        en     = 2'b11;
        unsync = 16'h5522;
        repeat (4) step();
        check("ch1_first_capture", 24'({obs[0][21], obs[0][15:8]}), 24'({1'b1, 8'h55}));
        en = 2'b01;
        step();
        en     = 2'b11;
        unsync = 16'h3C22;
        repeat (3) step();
        ack = 2'b10;
        step();
        check("ack_with_event_a", 24'({obs[0][23], obs[0][21], obs[0][19], obs[0][17], obs[0][15:8]}),
              24'({1'b1, 1'b1, 1'b0, 1'b1, 8'h3C}));
        check("ack_with_event_b", 24'({obs[1][23], obs[1][21], obs[1][19], obs[1][17], obs[1][15:8]}),
              24'({1'b1, 1'b1, 1'b0, 1'b1, 8'h3C}));
        ack = 2'b00;

        // Toggle-mode captures on the 3-stage instance.
        rst = 1'b0;
        en  = 2'b00;
        step();
        rst = 1'b1;
        for (int t = 0; t < 2; t++) begin
            en     = (t == 0) ? 2'b01 : 2'b00;
            unsync = (t == 0) ? 16'h0001 : 16'h0002;
            for (int j = 0; j < 6; j++) begin
                ack = (j == 5) ? 2'b01 : 2'b00;
                step();
                check($sformatf("tgl%0d_pulse_j%0d", t, j), 24'(obs[2][22]), 24'(j == 4));
            end
            ack = 2'b00;
            check($sformatf("tgl%0d_state", t), 24'({obs[2][20], obs[2][16], obs[2][7:0]}),
                  24'({1'b0, (t == 0), ((t == 0) ? 8'h01 : 8'h02)}));
        end
        en     = 2'b01;
        unsync = 16'h0003;
        step();
        rst = 1'b0;
        en  = 2'b00;
        step();
        check("tgl_reset_clears", obs[2], 24'h000000);
        rst    = 1'b1;
        pulses = 0;
        for (int j = 0; j < 6; j++) begin
            step();
            if (obs[2][22]) pulses++;
        end
        check("tgl_lost_event", 24'(pulses), 24'd0);

        // Randomized traffic on all three instances against the reference.
        rst = 1'b0;
        step();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 3) == 0) en[0] = ~en[0];
            if ($urandom_range(0, 3) == 0) en[1] = ~en[1];
            unsync = 16'($urandom);
            ack    = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            clr    = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
            step();
            for (int i = 0; i < 3; i++)
                check($sformatf("rand_cfg%0d_cyc%0d", i, cyc), obs[i],
                      {m_pulse[i], m_valid[i], m_ovr[i], m_tog[i], m_bus[i]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_sync_multi.md
Name: mux_sync_multi

Overview:
- Multi-channel bus MUX synchronizer; parametrised successor of the single-channel Data_Sync.
- Each channel brings an unsynchronised data bus plus its qualifying enable into the clk domain through a NUM_STAGES flop chain on the enable only, then captures the bus on the synchronised enable edge.
- Adds a consumer valid/ack handshake, overrun detection with a selectable overwrite/drop policy, a toggle-mode enable, and a toggle acknowledge returned to the source domain.
- Sits at the destination side of every multi-bit CDC crossing in the design.

Parameters:
NUM_STAGES, 2, enable synchronizer depth; legal range 2..4
BUS_WIDTH, 8, data bits per channel
NUM_CH, 2, number of independent channels
EN_MODE, 0, 0 = level enable, pulse on synchronised rising edge; 1 = toggle enable, pulse on any synchronised edge
OVERWRITE, 1, 1 = new capture overwrites unacknowledged data; 0 = new capture dropped while Data_Valid=1

Ports:
clk  in  1  destination clock; only clock in the block
rst  in  1  synchronous reset, active-low; sampled on rising clk
Unsync_Bus  in  NUM_CH*BUS_WIDTH  source data; channel c at bits [c*BUS_WIDTH +: BUS_WIDTH]; held stable by the source while its enable event propagates
Enable  in  NUM_CH  asynchronous per-channel enable, level or toggle per EN_MODE
Data_Ack  in  NUM_CH  consumer acknowledge, clk domain
Ovr_Clr  in  NUM_CH  clears the Overrun bit of the matching channel
Sync_Bus  out  NUM_CH*BUS_WIDTH  captured data per channel
Enable_Pulse  out  NUM_CH  one-cycle strobe per accepted capture
Data_Valid  out  NUM_CH  sticky valid; held until acknowledged
Overrun  out  NUM_CH  sticky error flag
Ack_Toggle  out  NUM_CH  toggles once per accepted Data_Ack; the source synchronizes it back into its own domain

Behaviour:
- Reset: when rst=0 at a clk edge, clear all sync flops, edge-detect flops, Sync_Bus, Enable_Pulse, Data_Valid, Overrun and Ack_Toggle to 0. Reset has priority over every event, including mid-propagation; an enable event in flight is lost.
- Channels are fully independent and must not interact.
- Sync chain: Enable[c] passes through NUM_STAGES flops. One further flop holds the previous synchronised value for edge detection.
- Edge detection:
  - EN_MODE=0: event = sync & ~prev.
  - EN_MODE=1: event = sync ^ prev.
  - Enable held high in level mode produces exactly one event.
- Latency: Enable changes before edge 0 and is sampled on edge 0. Enable_Pulse rises on edge NUM_STAGES+1 and is high for exactly one cycle. Sync_Bus updates on the same edge.
- Capture decision on each event:
  - Data_Valid=0, or Data_Ack=1 in the same cycle: load Sync_Bus, assert Enable_Pulse, set Data_Valid. No overrun.
  - Data_Valid=1 and Data_Ack=0: set Overrun.
    - OVERWRITE=1: load Sync_Bus and assert Enable_Pulse.
    - OVERWRITE=0: keep Sync_Bus and do not assert Enable_Pulse.
- Ack handling:
  - Data_Ack=1 with Data_Valid=1 and no event: clear Data_Valid on the next edge and toggle Ack_Toggle.
  - Data_Ack=1 with Data_Valid=1 and a simultaneous event: toggle Ack_Toggle; Data_Valid stays 1.
  - Data_Ack while Data_Valid=0 is ignored: no toggle, no state change.
- Overrun:
  - Cleared by Ovr_Clr=1.
  - If Ovr_Clr and a new overrun occur in the same cycle, set wins and Overrun stays 1.
- Sync_Bus holds its value between captures and is never cleared by Data_Ack.
- Combinational Unsync_Bus to Sync_Bus paths are forbidden; the bus is sampled only under the capture condition.
- Widths: all vector slices derive from NUM_CH and BUS_WIDTH. No arithmetic; no truncation permitted.

Test Plan:
1. Reset: drive rst=0 with Unsync_Bus=16'hFFFF and Enable=2'b11 for 2 cycles -> all outputs 0; no pulse after release until a new rising edge (EN_MODE=0).
2. Latency/one-shot: NUM_STAGES=2, ch0 Unsync_Bus=8'hA5, raise Enable[0] -> Enable_Pulse[0]=0 at edges 1-2, 1 at edge 3, 0 at edge 4 while Enable stays high; Sync_Bus[7:0]=8'hA5 and Data_Valid[0]=1 from edge 3; ch1 outputs unchanged.
3. Handshake: after test 2, pulse Data_Ack[0] for one cycle -> Data_Valid[0]=0 next edge; Ack_Toggle[0] 0->1; a second Data_Ack with Data_Valid=0 leaves Ack_Toggle=1.
4. Overrun:
   - OVERWRITE=1: capture 8'h11, no ack, capture 8'h22 -> Sync_Bus=8'h22, Overrun[0]=1, second Enable_Pulse present. Ovr_Clr -> Overrun=0.
   - OVERWRITE=0: same stimulus -> Sync_Bus=8'h11, no second pulse, Overrun=1.
5. Simultaneous ack and event: Data_Ack[1]=1 on the capture cycle of 8'h3C -> Data_Valid[1] stays 1, Sync_Bus ch1=8'h3C, Overrun[1]=0, Ack_Toggle[1] toggles.
6. Toggle mode: EN_MODE=1, flip Enable[0] 0->1->0 with data 8'h01 then 8'h02, spaced 6 cycles, acking each -> two single-cycle pulses, Sync_Bus 8'h01 then 8'h02. Reset asserted at edge 1 of a third toggle -> no pulse and all outputs 0.
